decode_regfile: RTL and testbench
=================================

Name: decode_regfile

Overview:
- Decode stage that sits directly downstream of the instruction fetch block.
- Latches fetch outputs into a D pipeline register with stall/bubble control, and derives srcA/srcB/dstE/dstM from icode/rA/rB.
- Holds the 15 x 64-bit Y86-64 register file: two read ports, two write ports driven by writeback (E and M).
- Produces valA/valB for execute, with write-through bypass from the same-cycle writeback.

Parameters:
- XLEN, 64, datapath width.
- NREG, 15, architectural registers, indices 0..14; 4'hF = RNONE.
- RSP_IDX, 4, stack pointer index.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- f_icode_i  in  4  fetch icode.
- f_ifun_i  in  4  fetch ifun.
- f_rA_i  in  4  fetch rA.
- f_rB_i  in  4  fetch rB.
- f_valC_i  in  64  fetch constant.
- f_valP_i  in  64  fetch next PC.
- f_instr_valid_i  in  1  fetch instruction-valid flag.
- f_imem_error_i  in  1  fetch memory-error flag.
- d_stall_i  in  1  hold D register.
- d_bubble_i  in  1  load NOP into D register.
- w_dstE_i  in  4  writeback E destination.
- w_valE_i  in  64  writeback E data.
- w_dstM_i  in  4  writeback M destination.
- w_valM_i  in  64  writeback M data.
- d_icode_o  out  4  latched icode.
- d_ifun_o  out  4  latched ifun.
- d_valC_o  out  64  latched valC.
- d_valP_o  out  64  latched valP.
- d_instr_valid_o  out  1  latched instruction-valid flag.
- d_imem_error_o  out  1  latched memory-error flag.
- srcA_o  out  4  read port A index.
- srcB_o  out  4  read port B index.
- dstE_o  out  4  E destination index.
- dstM_o  out  4  M destination index.
- valA_o  out  64  operand A.
- valB_o  out  64  operand B.

Behaviour:
- Clocking: one clock, clk_i; reset rst_i is synchronous, active-high.
- D register update, evaluated at each rising edge, priority order:
  - rst_i: icode=4'h1 (NOP), ifun=0, rA=rB=F, valC=valP=0, instr_valid=1, imem_error=0.
  - d_bubble_i: same values as reset.
  - d_stall_i: hold all fields.
  - otherwise: load all f_* inputs.
  - Bubble overrides stall when both are asserted.
- Register file at reset: all 15 entries cleared to 0. Writes presented in the reset cycle are discarded.
- Writes: at the rising edge, if w_dstE_i != F write w_valE_i; if w_dstM_i != F write w_valM_i.
  - If both ports target the same index, M wins (popq %rsp semantics).
  - Index F is never written.
- Source/destination decode, combinational from the D register (i=icode):
  - srcA = rA for i in {2,4,6,A}; RSP for i in {9,B}; else F.
  - srcB = rB for i in {4,5,6}; RSP for i in {8,9,A,B}; else F.
  - dstE = rB for i in {2,3,6}; RSP for i in {8,9,A,B}; else F. Cmov gating by ifun/cc happens downstream; dstE is unconditional here.
  - dstM = rA for i in {5,B}; else F.
- Reads are combinational. valB = 0 if srcB==F, else the bypass chain below.
- valA selection:
  - i in {7,8} (jxx, call): d_valP.
  - srcA==F: 0.
  - else bypass chain.
- Bypass chain, priority order:
  - w_dstM_i==src: w_valM_i.
  - w_dstE_i==src: w_valE_i.
  - else array entry.
  - The value read therefore equals the value stored after the edge.
- Latency: D register outputs valid one cycle after load; valA/valB valid in the same cycle as the D outputs.
- Invalid icode (>= C) passes through unchanged with the latched flags. src/dst all F, valA=valB=0; no other side effects.
- Reset mid-stall: reset wins, D becomes NOP.
- Registers are not affected by d_stall_i or d_bubble_i.

Decomposition:
- Shared package: icode constants (IHALT..IPOPQ), RNONE=4'hF, RSP=4'h4, NOP bubble field values.
- Natural sub-module: regfile_2r2w. It holds the array, reset clear, dual write with M priority, and two combinational bypassed read ports.
- decode_regfile instantiates regfile_2r2w and holds the D register plus src/dst decode.

Test Plan:
- Reset, then f_icode=3, rB=8, valC=8 loaded -> next cycle d_icode=3, dstE=8, srcA=srcB=F, valA=valB=0.
- Write w_dstE=3, w_valE=0x21; then decode 6/1 with rA=2, rB=3 -> srcA=2, srcB=3, valB=0x21, valA=0, dstE=3.
- Same-cycle bypass: decode pushq rA=2 while w_dstE=2, w_valE=0x55 -> valA=0x55 that cycle; register 2 holds 0x55 afterwards.
- w_dstE=4 (0x100) and w_dstM=4 (0x200) in the same cycle -> reg4=0x200; a following popq shows valA=valB=0x200.
- call: f_icode=8, valP=0x2A -> valA=0x2A, srcB=dstE=4. Stall asserted -> outputs held 3 cycles. Bubble -> d_icode=1, all src/dst F.
- Assert rst_i after writing reg1=7 and while stalled -> next cycle reg1 reads 0 and D holds NOP. Stall+bubble together -> NOP.

Source files
------------

// File: rtl/decode_regfile_pkg.sv
// rtl/decode_regfile_pkg.sv - shared constants and types for the Y86-64 decode stage
package decode_regfile_pkg;

    localparam int XLEN = 64;
    localparam int NREG = 15;

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    typedef struct packed {
        logic [3:0]      icode;
        logic [3:0]      ifun;
        logic [3:0]      rA;
        logic [3:0]      rB;
        logic [XLEN-1:0] valC;
        logic [XLEN-1:0] valP;
        logic            instr_valid;
        logic            imem_error;
    } d_reg_t;

    // Contents loaded into the D register on reset or bubble
    localparam d_reg_t D_NOP = '{
        icode:       INOP,
        ifun:        4'h0,
        rA:          RNONE,
        rB:          RNONE,
        valC:        {XLEN{1'b0}},
        valP:        {XLEN{1'b0}},
        instr_valid: 1'b1,
        imem_error:  1'b0
    };

endpackage

// File: rtl/decode_regfile_if.sv
// rtl/decode_regfile_if.sv - writeback bus carrying the E and M register writes
interface decode_regfile_if;
    import decode_regfile_pkg::*;

    logic [3:0]      dstE;
    logic [XLEN-1:0] valE;
    logic [3:0]      dstM;
    logic [XLEN-1:0] valM;

    modport master (output dstE, valE, dstM, valM);
    modport slave  (input  dstE, valE, dstM, valM);

endinterface

// File: rtl/decode_regfile_regfile_2r2w.sv
// rtl/decode_regfile_regfile_2r2w.sv - 15x64 register file, two bypassed reads, two writes (M wins)
module regfile_2r2w
    import decode_regfile_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    decode_regfile_if.slave    wb,
    input  logic [3:0]         rd_a_idx_i,
    input  logic [3:0]         rd_b_idx_i,
    output logic [XLEN-1:0]    rd_a_data_o,
    output logic [XLEN-1:0]    rd_b_data_o
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    // M is applied after E so a popq %rsp leaves the popped value in %rsp
    always_comb begin
        regs_d = regs_q;
        if (wb.dstE != RNONE) begin
            regs_d[wb.dstE] = wb.valE;
        end
        if (wb.dstM != RNONE) begin
            regs_d[wb.dstM] = wb.valM;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    function automatic logic [XLEN-1:0] bypass_read(
        input logic [3:0]      idx,
        input logic [3:0]      dst_m,
        input logic [XLEN-1:0] val_m,
        input logic [3:0]      dst_e,
        input logic [XLEN-1:0] val_e,
        input logic [XLEN-1:0] stored
    );
        if (idx == RNONE) begin
            return '0;
        end else if (dst_m == idx) begin
            return val_m;
        end else if (dst_e == idx) begin
            return val_e;
        end
        return stored;
    endfunction

    logic [XLEN-1:0] stored_a;
    logic [XLEN-1:0] stored_b;

    always_comb begin
        stored_a = '0;
        stored_b = '0;
        if (rd_a_idx_i != RNONE) begin
            stored_a = regs_q[rd_a_idx_i];
        end
        if (rd_b_idx_i != RNONE) begin
            stored_b = regs_q[rd_b_idx_i];
        end
    end

    assign rd_a_data_o = bypass_read(rd_a_idx_i, wb.dstM, wb.valM, wb.dstE, wb.valE, stored_a);
    assign rd_b_data_o = bypass_read(rd_b_idx_i, wb.dstM, wb.valM, wb.dstE, wb.valE, stored_b);

endmodule

// File: rtl/decode_regfile.sv
// rtl/decode_regfile.sv - Y86-64 decode stage: D pipeline register, src/dst decode, register file
module decode_regfile
    import decode_regfile_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [3:0]      f_icode_i,
    input  logic [3:0]      f_ifun_i,
    input  logic [3:0]      f_rA_i,
    input  logic [3:0]      f_rB_i,
    input  logic [XLEN-1:0] f_valC_i,
    input  logic [XLEN-1:0] f_valP_i,
    input  logic            f_instr_valid_i,
    input  logic            f_imem_error_i,
    input  logic            d_stall_i,
    input  logic            d_bubble_i,
    input  logic [3:0]      w_dstE_i,
    input  logic [XLEN-1:0] w_valE_i,
    input  logic [3:0]      w_dstM_i,
    input  logic [XLEN-1:0] w_valM_i,
    output logic [3:0]      d_icode_o,
    output logic [3:0]      d_ifun_o,
    output logic [XLEN-1:0] d_valC_o,
    output logic [XLEN-1:0] d_valP_o,
    output logic            d_instr_valid_o,
    output logic            d_imem_error_o,
    output logic [3:0]      srcA_o,
    output logic [3:0]      srcB_o,
    output logic [3:0]      dstE_o,
    output logic [3:0]      dstM_o,
    output logic [XLEN-1:0] valA_o,
    output logic [XLEN-1:0] valB_o
);

    d_reg_t d_q;
    d_reg_t d_d;

    // Bubble takes priority over stall
    always_comb begin
        d_d = d_q;
        if (d_bubble_i) begin
            d_d = D_NOP;
        end else if (!d_stall_i) begin
            d_d.icode       = f_icode_i;
            d_d.ifun        = f_ifun_i;
            d_d.rA          = f_rA_i;
            d_d.rB          = f_rB_i;
            d_d.valC        = f_valC_i;
            d_d.valP        = f_valP_i;
            d_d.instr_valid = f_instr_valid_i;
            d_d.imem_error  = f_imem_error_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d_q <= D_NOP;
        end else begin
            d_q <= d_d;
        end
    end

    assign d_icode_o       = d_q.icode;
    assign d_ifun_o        = d_q.ifun;
    assign d_valC_o        = d_q.valC;
    assign d_valP_o        = d_q.valP;
    assign d_instr_valid_o = d_q.instr_valid;
    assign d_imem_error_o  = d_q.imem_error;

    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;

    // dstE is unconditional; cmov gating happens in execute
    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (d_q.icode)
            IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: src_a = d_q.rA;
            IRET, IPOPQ:                    src_a = RSP;
            default:                        src_a = RNONE;
        endcase
        case (d_q.icode)
            IRMMOVQ, IMRMOVQ, IOPQ:         src_b = d_q.rB;
            ICALL, IRET, IPUSHQ, IPOPQ:     src_b = RSP;
            default:                        src_b = RNONE;
        endcase
        case (d_q.icode)
            IRRMOVQ, IIRMOVQ, IOPQ:         dst_e = d_q.rB;
            ICALL, IRET, IPUSHQ, IPOPQ:     dst_e = RSP;
            default:                        dst_e = RNONE;
        endcase
        case (d_q.icode)
            IMRMOVQ, IPOPQ:                 dst_m = d_q.rA;
            default:                        dst_m = RNONE;
        endcase
    end

    assign srcA_o = src_a;
    assign srcB_o = src_b;
    assign dstE_o = dst_e;
    assign dstM_o = dst_m;

    decode_regfile_if wb_bus ();

    assign wb_bus.dstE = w_dstE_i;
    assign wb_bus.valE = w_valE_i;
    assign wb_bus.dstM = w_dstM_i;
    assign wb_bus.valM = w_valM_i;

    logic [XLEN-1:0] rd_a_data;
    logic [XLEN-1:0] rd_b_data;

    regfile_2r2w u_regfile (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wb          (wb_bus.slave),
        .rd_a_idx_i  (src_a),
        .rd_b_idx_i  (src_b),
        .rd_a_data_o (rd_a_data),
        .rd_b_data_o (rd_b_data)
    );

    // jXX and call carry the fall-through PC to execute in place of a register
    assign valA_o = (d_q.icode == IJXX || d_q.icode == ICALL) ? d_q.valP : rd_a_data;
    assign valB_o = rd_b_data;

endmodule

// File: tb/tb_decode_regfile.sv
// tb/tb_decode_regfile.sv - randomized and directed bench for decode_regfile against a reference model
module tb_decode_regfile;
    import decode_regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
    logic [63:0] f_valC, f_valP;
    logic        f_iv, f_ie, stall, bubble;

    logic [3:0]  d_icode, d_ifun, srcA, srcB, dstE, dstM;
    logic [63:0] d_valC, d_valP, valA, valB;
    logic        d_iv, d_ie;

    decode_regfile_if wb ();

    always #5 clk = ~clk;

    decode_regfile dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .f_icode_i       (f_icode),
        .f_ifun_i        (f_ifun),
        .f_rA_i          (f_rA),
        .f_rB_i          (f_rB),
        .f_valC_i        (f_valC),
        .f_valP_i        (f_valP),
        .f_instr_valid_i (f_iv),
        .f_imem_error_i  (f_ie),
        .d_stall_i       (stall),
        .d_bubble_i      (bubble),
        .w_dstE_i        (wb.dstE),
        .w_valE_i        (wb.valE),
        .w_dstM_i        (wb.dstM),
        .w_valM_i        (wb.valM),
        .d_icode_o       (d_icode),
        .d_ifun_o        (d_ifun),
        .d_valC_o        (d_valC),
        .d_valP_o        (d_valP),
        .d_instr_valid_o (d_iv),
        .d_imem_error_o  (d_ie),
        .srcA_o          (srcA),
        .srcB_o          (srcB),
        .dstE_o          (dstE),
        .dstM_o          (dstM),
        .valA_o          (valA),
        .valB_o          (valB)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: architectural register values and the latched D fields
    logic [63:0] m_regs [15];
    logic [3:0]  m_icode, m_ifun, m_rA, m_rB;
    logic [63:0] m_valC, m_valP;
    logic        m_iv, m_ie;

    task automatic model_nop();
        m_icode = 4'h1; m_ifun = 4'h0; m_rA = 4'hF; m_rB = 4'hF;
        m_valC = 64'h0; m_valP = 64'h0; m_iv = 1'b1; m_ie = 1'b0;
    endtask

    function automatic logic [3:0] exp_src_a(input logic [3:0] i, input logic [3:0] ra);
        if (i inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (i inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] exp_src_b(input logic [3:0] i, input logic [3:0] rb);
        if (i inside {4'h4, 4'h5, 4'h6}) return rb;
        if (i inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] exp_dst_e(input logic [3:0] i, input logic [3:0] rb);
        if (i inside {4'h2, 4'h3, 4'h6}) return rb;
        if (i inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] exp_dst_m(input logic [3:0] i, input logic [3:0] ra);
        return (i inside {4'h5, 4'hB}) ? ra : 4'hF;
    endfunction

    // A read returns what the register will hold once this cycle's writes land
    function automatic logic [63:0] after_write(input logic [3:0] idx);
        logic [63:0] v;
        if (idx == 4'hF) return 64'h0;
        v = m_regs[idx];
        if (wb.dstE == idx) v = wb.valE;
        if (wb.dstM == idx) v = wb.valM;
        return v;
    endfunction

    task automatic check_model();
        logic [3:0]  sa, sb;
        logic [63:0] va;
        sa = exp_src_a(m_icode, m_rA);
        sb = exp_src_b(m_icode, m_rB);
        va = (m_icode inside {4'h7, 4'h8}) ? m_valP : after_write(sa);
        check_eq("d_icode", d_icode, m_icode);
        check_eq("d_ifun", d_ifun, m_ifun);
        check_eq("d_valC", d_valC, m_valC);
        check_eq("d_valP", d_valP, m_valP);
        check_eq("d_instr_valid", d_iv, m_iv);
        check_eq("d_imem_error", d_ie, m_ie);
        check_eq("srcA", srcA, sa);
        check_eq("srcB", srcB, sb);
        check_eq("dstE", dstE, exp_dst_e(m_icode, m_rB));
        check_eq("dstM", dstM, exp_dst_m(m_icode, m_rA));
        check_eq("valA", valA, va);
        check_eq("valB", valB, after_write(sb));
    endtask

    task automatic cycle();
        #1;
        check_model();
        @(posedge clk);
        if (rst) begin
            model_nop();
            for (int i = 0; i < 15; i++) m_regs[i] = 64'h0;
        end else begin
            if (wb.dstE != 4'hF) m_regs[wb.dstE] = wb.valE;
            if (wb.dstM != 4'hF) m_regs[wb.dstM] = wb.valM;
            if (bubble) begin
                model_nop();
            end else if (!stall) begin
                m_icode = f_icode; m_ifun = f_ifun; m_rA = f_rA; m_rB = f_rB;
                m_valC = f_valC; m_valP = f_valP; m_iv = f_iv; m_ie = f_ie;
            end
        end
        @(negedge clk);
    endtask

    task automatic no_wb();
        wb.dstE = 4'hF; wb.valE = 64'h0; wb.dstM = 4'hF; wb.valM = 64'h0;
    endtask

    task automatic set_f(input logic [3:0] i, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] vc, input logic [63:0] vp);
        f_icode = i; f_ifun = 4'h0; f_rA = ra; f_rB = rb;
        f_valC = vc; f_valP = vp; f_iv = 1'b1; f_ie = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; bubble = 1'b0;
        no_wb();
        set_f(4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
        model_nop();
        for (int i = 0; i < 15; i++) m_regs[i] = 64'h0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_icode", d_icode, 64'h1);
        check_eq("rst_srcA", srcA, 64'hF);
        check_eq("rst_dstE", dstE, 64'hF);
        check_eq("rst_valA", valA, 64'h0);
        cycle();
        rst = 1'b0;

        // irmovq into %r8
        set_f(4'h3, 4'hF, 4'h8, 64'h8, 64'h10);
        cycle();
        #1;
        check_eq("t1_icode", d_icode, 64'h3);
        check_eq("t1_dstE", dstE, 64'h8);
        check_eq("t1_srcA", srcA, 64'hF);
        check_eq("t1_srcB", srcB, 64'hF);
        check_eq("t1_valB", valB, 64'h0);

        // opq rA=2 rB=3 after writing reg3
        wb.dstE = 4'h3; wb.valE = 64'h21;
        set_f(4'h6, 4'h2, 4'h3, 64'h0, 64'h12);
        f_ifun = 4'h1;
        cycle();
        no_wb();
        #1;
        check_eq("t2_srcA", srcA, 64'h2);
        check_eq("t2_srcB", srcB, 64'h3);
        check_eq("t2_valB", valB, 64'h21);
        check_eq("t2_valA", valA, 64'h0);
        check_eq("t2_dstE", dstE, 64'h3);

        // pushq rA=2 with same-cycle write to reg2
        set_f(4'hA, 4'h2, 4'hF, 64'h0, 64'h14);
        cycle();
        wb.dstE = 4'h2; wb.valE = 64'h55;
        #1;
        check_eq("t3_bypass", valA, 64'h55);
        cycle();
        no_wb();
        #1;
        check_eq("t3_stored", valA, 64'h55);

        // both ports write %rsp, M wins; then popq
        wb.dstE = 4'h4; wb.valE = 64'h100; wb.dstM = 4'h4; wb.valM = 64'h200;
        set_f(4'hB, 4'h0, 4'hF, 64'h0, 64'h16);
        cycle();
        no_wb();
        #1;
        check_eq("t4_valA", valA, 64'h200);
        check_eq("t4_valB", valB, 64'h200);

        // call, then stall for three cycles, then bubble
        set_f(4'h8, 4'hF, 4'hF, 64'h40, 64'h2A);
        cycle();
        #1;
        check_eq("t5_valA", valA, 64'h2A);
        check_eq("t5_srcB", srcB, 64'h4);
        check_eq("t5_dstE", dstE, 64'h4);
        stall = 1'b1;
        set_f(4'h3, 4'h1, 4'h2, 64'h99, 64'h77);
        for (int k = 0; k < 3; k++) begin
            cycle();
            #1;
            check_eq("t5_hold_icode", d_icode, 64'h8);
            check_eq("t5_hold_valA", valA, 64'h2A);
        end
        stall = 1'b0; bubble = 1'b1;
        cycle();
        bubble = 1'b0;
        #1;
        check_eq("t5_bub_icode", d_icode, 64'h1);
        check_eq("t5_bub_src", {srcA, srcB, dstE, dstM}, 64'hFFFF);

        // reset while stalled clears reg1 and D
        wb.dstE = 4'h1; wb.valE = 64'h7; stall = 1'b1;
        cycle();
        no_wb();
        rst = 1'b1;
        cycle();
        rst = 1'b0; stall = 1'b0;
        #1;
        check_eq("t6_icode", d_icode, 64'h1);
        set_f(4'h2, 4'h1, 4'h5, 64'h0, 64'h20);
        cycle();
        #1;
        check_eq("t6_reg1", valA, 64'h0);

        // stall and bubble together
        stall = 1'b1; bubble = 1'b1;
        set_f(4'h6, 4'h1, 4'h2, 64'h0, 64'h22);
        cycle();
        stall = 1'b0; bubble = 1'b0;
        #1;
        check_eq("t7_icode", d_icode, 64'h1);

        for (int n = 0; n < 600; n++) begin
            rst    = ($urandom_range(0, 59) == 0);
            stall  = ($urandom_range(0, 4) == 0);
            bubble = ($urandom_range(0, 9) == 0);
            f_icode = 4'($urandom_range(0, 15));
            f_ifun  = 4'($urandom_range(0, 15));
            f_rA    = 4'($urandom_range(0, 15));
            f_rB    = 4'($urandom_range(0, 15));
            f_valC  = {$urandom, $urandom};
            f_valP  = {$urandom, $urandom};
            f_iv    = 1'($urandom_range(0, 1));
            f_ie    = 1'($urandom_range(0, 1));
            wb.dstE = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            wb.dstM = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            if ($urandom_range(0, 7) == 0) wb.dstM = wb.dstE;
            wb.valE = {$urandom, $urandom};
            wb.valM = {$urandom, $urandom};
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
